alu_inst_encoder: RTL and testbench

- Instruction-stream generator; the encoding counterpart of the CPU's ALU-control decoder.
- Accepts ALU operation requests (4-bit alu_op, register indices, immediate) over a valid/ready handshake.
- Encodes each request into a 32-bit RV32I R-type or I-type word, buffers it in a FIFO and streams it with sequential addresses into instruction-memory load logic.
- Closes each program with an ECALL terminator. Used to build self-checking programs for the single-cycle CPU.

---
 rtl/alu_inst_encoder.sv | 168 ++++++++++++++++
 tb/tb_alu_inst_encoder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_inst_encoder.sv
// alu_inst_encoder: turns ALU operation requests into RV32I R-type / I-type
// instruction words, buffers them in a small FIFO and streams them out with
// sequential byte addresses, closing each program with an ECALL terminator.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   start, finish     one-cycle program begin / end pulses
//   req_*             request channel (valid/ready), op + operands
//   inst_*            instruction output channel (valid/ready), word + address
//   busy              program in progress (not IDLE or DONE)
//   err               one-cycle pulse after an illegal request was dropped
module alu_inst_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        finish,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_alu_op,
    input  logic        req_use_imm,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [11:0] req_imm,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_addr,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = AW + 1;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        TERM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;

    logic            legal;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [11:0]     imm12;
    logic [31:0]     wdata;
    logic [31:0]     head_n;
    logic            accept;
    logic            push;
    logic            out_hs;
    logic            pop;

    // Request encoder: op -> funct3/funct7, legality, immediate shaping
    always_comb begin
        legal  = 1'b1;
        funct3 = 3'b000;
        funct7 = 7'b000_0000;
        case (req_alu_op)
            4'b0000: funct3 = 3'b111;
            4'b0001: funct3 = 3'b110;
            4'b0010: funct3 = 3'b000;
            4'b0110: begin
                funct3 = 3'b000;
                funct7 = 7'b010_0000;
                legal  = ~req_use_imm;   // there is no SUBI
            end
            4'b0011: funct3 = 3'b001;
            4'b0111: funct3 = 3'b100;
            4'b1000: funct3 = 3'b101;
            default: legal  = 1'b0;
        endcase
        // Shift immediates carry only a 5-bit shamt; upper bits must be zero
        if (req_alu_op == 4'b0011 || req_alu_op == 4'b1000) begin
            imm12 = {7'b000_0000, req_imm[4:0]};
        end else begin
            imm12 = req_imm;
        end
        if (req_use_imm) begin
            wdata = {imm12, req_rs1, funct3, req_rd, 7'b0010011};
        end else begin
            wdata = {funct7, req_rs2, req_rs1, funct3, req_rd, 7'b0110011};
        end
    end

    // Handshakes, FIFO next state and next-state decode
    always_comb begin
        accept   = req_valid & req_ready;
        push     = accept & legal;
        out_hs   = inst_valid & inst_ready;
        pop      = out_hs & (state != TERM);
        count_n  = count + CW'(push) - CW'(pop);
        rd_ptr_n = rd_ptr + AW'(pop);
        // Entry that will sit at the head after this edge; an empty FIFO
        // being written forwards the incoming word.
        if ((count - CW'(pop)) != '0) begin
            head_n = mem[rd_ptr_n];
        end else begin
            head_n = wdata;
        end

        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (finish) state_n = DRAIN;
            DRAIN:   if (count_n == '0) state_n = TERM;
            TERM:    if (out_hs) state_n = DONE;
            DONE:    if (start) state_n = RUN;
            default: state_n = IDLE;
        endcase
    end

    // State, FIFO storage, address counter and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            inst_addr  <= BASE_ADDR;
            req_ready  <= 1'b0;
            inst_valid <= 1'b0;
            inst_word  <= 32'h0000_0000;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            rd_ptr <= rd_ptr_n;
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end

            if ((state == IDLE || state == DONE) && start) begin
                inst_addr <= BASE_ADDR;
            end else if (out_hs) begin
                inst_addr <= inst_addr + 32'd4;
            end

            req_ready  <= (state_n == RUN) && (count_n < CW'(DEPTH));
            inst_valid <= (state_n == TERM) ||
                          ((state_n == RUN || state_n == DRAIN) && (count_n != '0));
            if (state_n == TERM) begin
                inst_word <= ECALL;
            end else if (count_n != '0) begin
                inst_word <= head_n;
            end
            busy <= (state_n != IDLE) && (state_n != DONE);
            err  <= accept & ~legal;
        end
    end

endmodule

// File: tb/tb_alu_inst_encoder.sv
module tb_alu_inst_encoder;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_alu_op = 4'd0;
    logic        req_use_imm = 1'b0;
    logic [4:0]  req_rd = 5'd0;
    logic [4:0]  req_rs1 = 5'd0;
    logic [4:0]  req_rs2 = 5'd0;
    logic [11:0] req_imm = 12'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_word;
    logic [31:0] inst_addr;
    logic        busy;
    logic        err;

    alu_inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .req_alu_op(req_alu_op),
        .req_use_imm(req_use_imm), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_word(inst_word), .inst_addr(inst_addr),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum {P_IDLE, P_RUN, P_DRAIN, P_TERM, P_DONE} phase_t;
    phase_t      m_phase = P_IDLE;
    phase_t      m_old;
    logic [31:0] m_q[$];
    logic [31:0] m_addr = BASE;
    bit          m_err = 1'b0;
    bit          m_live = 1'b0;
    bit          m_hs_in, m_hs_out, m_bad;

    function automatic logic [31:0] model_enc(input logic [3:0] op, input logic ui,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [11:0] imm);
        int f3;
        logic [11:0] i;
        case (op)
            4'd0: f3 = 7;
            4'd1: f3 = 6;
            4'd2, 4'd6: f3 = 0;
            4'd3: f3 = 1;
            4'd7: f3 = 4;
            4'd8: f3 = 5;
            default: f3 = 0;
        endcase
        if (ui) begin
            i = (op == 4'd3 || op == 4'd8) ? (imm & 12'h01F) : imm;
            return (32'(i) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
        end
        return (32'((op == 4'd6) ? 32 : 0) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
             | (32'(f3) << 12) | (32'(rd) << 7) | 32'h33;
    endfunction

    function automatic bit model_illegal(input logic [3:0] op, input logic ui);
        bit listed;
        listed = (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd6) ||
                 (op == 4'd3) || (op == 4'd7) || (op == 4'd8);
        return !listed || (op == 4'd6 && ui);
    endfunction

    function automatic bit m_ready();
        return m_phase == P_RUN && m_q.size() < DEPTH;
    endfunction

    function automatic bit m_valid();
        return m_phase == P_TERM || ((m_phase == P_RUN || m_phase == P_DRAIN) && m_q.size() > 0);
    endfunction

    function automatic logic [31:0] m_word();
        if (m_phase == P_TERM) return 32'h0000_0073;
        return m_q[0];
    endfunction

    always @(posedge clk) begin : model_p
        if (!reset) begin
            m_phase = P_IDLE;
            m_q.delete();
            m_addr  = BASE;
            m_err   = 1'b0;
        end else begin
            m_old    = m_phase;
            m_hs_in  = req_valid && m_ready();
            m_hs_out = m_valid() && inst_ready;
            m_bad    = model_illegal(req_alu_op, req_use_imm);
            m_err    = m_hs_in && m_bad;
            if (m_hs_out) begin
                m_addr = m_addr + 32'd4;
                if (m_old != P_TERM) void'(m_q.pop_front());
            end
            if (m_hs_in && !m_bad)
                m_q.push_back(model_enc(req_alu_op, req_use_imm, req_rd, req_rs1, req_rs2, req_imm));
            case (m_old)
                P_IDLE, P_DONE: if (start) begin m_phase = P_RUN; m_addr = BASE; end
                P_RUN:          if (finish) m_phase = P_DRAIN;
                P_DRAIN:        if (m_q.size() == 0) m_phase = P_TERM;
                P_TERM:         if (m_hs_out) m_phase = P_DONE;
                default:        m_phase = P_IDLE;
            endcase
        end
        m_live = 1'b1;
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            chk("req_ready", 32'(req_ready), 32'(m_ready()));
            chk("inst_valid", 32'(inst_valid), 32'(m_valid()));
            chk("inst_addr", inst_addr, m_addr);
            chk("busy", 32'(busy), 32'(m_phase != P_IDLE && m_phase != P_DONE));
            chk("err", 32'(err), 32'(m_err));
            if (m_valid()) chk("inst_word", inst_word, m_word());
        end
    end

    // ---------------- stimulus helpers (entered at posedge+2) ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic ui, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im,
                        input logic fin);
        bit ok = 1'b0;
        req_alu_op = op; req_use_imm = ui; req_rd = d; req_rs1 = s1; req_rs2 = s2;
        req_imm = im; req_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            else begin @(posedge clk); #2; end
        end
        chk("send_accept_timeout", 32'(ok), 32'd1);
        if (ok) finish = fin;
        @(posedge clk); #2;
        req_valid = 1'b0;
        finish = 1'b0;
    endtask

    task automatic expect_now(input string name, input logic [31:0] w, input logic [31:0] a);
        @(negedge clk);
        chk({name, "_valid"}, 32'(inst_valid), 32'd1);
        chk({name, "_word"}, inst_word, w);
        chk({name, "_addr"}, inst_addr, a);
        @(posedge clk); #2;
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (!busy) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
        @(posedge clk); #2;
    endtask

    logic [3:0] ops [9];
    bit         hs_pending;
    bit         seen_ecall;

    initial begin
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd3, 4'd7, 4'd8, 4'hF, 4'h4};

        // Pin the model's encoder to hand-computed words
        chk("model_add",  model_enc(4'd2, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0),   32'h002081B3);
        chk("model_sub",  model_enc(4'd6, 1'b0, 5'd5, 5'd6, 5'd7, 12'h0),   32'h407302B3);
        chk("model_addi", model_enc(4'd2, 1'b1, 5'd1, 5'd0, 5'd0, 12'hFFF), 32'hFFF00093);
        chk("model_slli", model_enc(4'd3, 1'b1, 5'd2, 5'd2, 5'd0, 12'hFE3), 32'h00311113);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_word", inst_word, 32'h0);
        chk("rst_inst_addr", inst_addr, BASE);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;

        // Single words, streaming consumer
        inst_ready = 1'b1;
        pulse_start();
        send(4'd2, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0, 1'b0);
        expect_now("add", 32'h002081B3, 32'd0);
        send(4'd6, 1'b0, 5'd5, 5'd6, 5'd7, 12'h0, 1'b0);
        expect_now("sub", 32'h407302B3, 32'd4);
        send(4'd2, 1'b1, 5'd1, 5'd0, 5'd0, 12'hFFF, 1'b0);
        expect_now("addi", 32'hFFF00093, 32'd8);
        send(4'd3, 1'b1, 5'd2, 5'd2, 5'd0, 12'hFE3, 1'b0);
        expect_now("slli", 32'h00311113, 32'd12);

        // Fill the FIFO against a stalled consumer
        inst_ready = 1'b0;
        send(4'd2, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0, 1'b0);
        send(4'd0, 1'b0, 5'd4, 5'd5, 5'd6, 12'h0, 1'b0);
        send(4'd7, 1'b1, 5'd7, 5'd8, 5'd0, 12'h123, 1'b0);
        send(4'd8, 1'b1, 5'd9, 5'd10, 5'd0, 12'hABC, 1'b0);
        req_alu_op = 4'd1; req_use_imm = 1'b0; req_rd = 5'd11; req_rs1 = 5'd12;
        req_rs2 = 5'd13; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_req_ready", 32'(req_ready), 32'd0);
            chk("stall_word", inst_word, 32'h002081B3);
            chk("stall_addr", inst_addr, 32'd16);
            @(posedge clk); #2;
        end
        inst_ready = 1'b1;
        send(4'd1, 1'b0, 5'd11, 5'd12, 5'd13, 12'h0, 1'b0);
        repeat (8) @(posedge clk);
        #2;

        // Illegal requests: err pulse, nothing emitted, counter unchanged
        send(4'd6, 1'b1, 5'd1, 5'd2, 5'd0, 12'h5, 1'b0);
        @(negedge clk);
        chk("ill_subi_err", 32'(err), 32'd1);
        chk("ill_subi_valid", 32'(inst_valid), 32'd0);
        chk("ill_subi_addr", inst_addr, 32'd36);
        @(posedge clk); #2;
        @(negedge clk);
        chk("ill_err_one_cycle", 32'(err), 32'd0);
        @(posedge clk); #2;
        send(4'hF, 1'b0, 5'd1, 5'd2, 5'd3, 12'h0, 1'b0);
        @(negedge clk);
        chk("ill_opF_err", 32'(err), 32'd1);
        chk("ill_opF_addr", inst_addr, 32'd36);
        @(posedge clk); #2;

        // Randomized traffic with a random consumer and stray start pulses
        req_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            hs_pending = req_valid && req_ready;
            @(posedge clk); #2;
            if (hs_pending || !req_valid) begin
                req_valid   = ($urandom % 4) != 0;
                req_alu_op  = ops[$urandom % 9];
                req_use_imm = 1'($urandom % 2);
                req_rd      = 5'($urandom);
                req_rs1     = 5'($urandom);
                req_rs2     = 5'($urandom);
                req_imm     = 12'($urandom);
            end
            inst_ready = ($urandom % 3) != 0;
            start      = ($urandom % 16) == 0;
        end
        start = 1'b0;
        req_valid = 1'b0;
        finish = 1'b1;
        @(posedge clk); #2;
        finish = 1'b0;
        inst_ready = 1'b1;
        wait_idle("random_done_timeout");

        // Program with finish coinciding with the last request
        pulse_start();
        send(4'd2, 1'b0, 5'd1, 5'd2, 5'd3, 12'h0, 1'b0);
        send(4'd1, 1'b1, 5'd4, 5'd5, 5'd0, 12'h7F0, 1'b0);
        send(4'd7, 1'b0, 5'd6, 5'd7, 5'd8, 12'h0, 1'b0);
        send(4'd0, 1'b1, 5'd9, 5'd10, 5'd0, 12'h0FF, 1'b1);
        seen_ecall = 1'b0;
        for (int i = 0; i < 40 && !seen_ecall; i++) begin
            @(negedge clk);
            if (inst_valid && inst_word == 32'h0000_0073) begin
                seen_ecall = 1'b1;
                chk("ecall_addr", inst_addr, 32'd16);
            end
        end
        chk("ecall_seen", 32'(seen_ecall), 32'd1);
        @(posedge clk); #2;
        wait_idle("term_done_timeout");
        pulse_start();
        send(4'd2, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0, 1'b0);
        expect_now("restart", 32'h002081B3, BASE);

        // Reset with three held entries: they must never appear
        inst_ready = 1'b0;
        send(4'd0, 1'b0, 5'd1, 5'd1, 5'd1, 12'h0, 1'b0);
        send(4'd1, 1'b0, 5'd2, 5'd2, 5'd2, 12'h0, 1'b0);
        send(4'd2, 1'b0, 5'd3, 5'd3, 5'd3, 12'h0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 32'(inst_valid), 32'd0);
        chk("mrst_addr", inst_addr, BASE);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #2;
        inst_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        pulse_start();
        send(4'd7, 1'b0, 5'd9, 5'd8, 5'd7, 12'h0, 1'b0);
        expect_now("post_rst", model_enc(4'd7, 1'b0, 5'd9, 5'd8, 5'd7, 12'h0), BASE);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
